uart_multi_router: RTL and testbench



---
 rtl/uart_multi_router.sv | 150 +++++++++++++++
 tb/tb_uart_multi_router.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_multi_router.sv
// N-port command router: demuxes length-prefixed packets from the UART command stream to
// target ports, and merges single-word port responses back upstream behind a routing header.
module uart_multi_router #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               command_word_i,
  input  logic                      command_valid_i,
  output logic                      command_ready_o,
  output logic [31:0]               command_word_o,
  output logic                      command_valid_o,
  input  logic                      command_ready_i,
  output logic [32*NUM_PORTS-1:0]   port_word_o,
  output logic [NUM_PORTS-1:0]      port_valid_o,
  input  logic [NUM_PORTS-1:0]      port_ready_i,
  input  logic [32*NUM_PORTS-1:0]   port_word_i,
  input  logic [NUM_PORTS-1:0]      port_valid_i,
  output logic [NUM_PORTS-1:0]      port_ready_o,
  output logic [15:0]               drop_cnt_o
);

  typedef enum logic [1:0] {DS_IDLE, DS_FWD, DS_DISC} ds_state_e;
  typedef enum logic {US_IDLE, US_PAYLOAD} us_state_e;

  ds_state_e         ds_q;
  us_state_e         us_q;
  logic [15:0]       word_cnt_q, out_port_q, drop_cnt_q;
  logic [PORT_W-1:0] grant_q, rr_ptr_q;

  logic [PORT_W-1:0] out_idx, sel, idx;
  logic              fwd_ok, any_vld, ds_hs, us_hs;
  logic [31:0]       gword;

  assign port_word_o = {NUM_PORTS{command_word_i}};
  assign drop_cnt_o  = drop_cnt_q;
  assign out_idx     = out_port_q[PORT_W-1:0];
  assign fwd_ok      = 32'(out_port_q) < NUM_PORTS;
  assign ds_hs       = command_valid_i & command_ready_o;
  assign us_hs       = command_valid_o & command_ready_i;

  // Downstream datapath: combinational pass-through to the latched target
  always_comb begin
    port_valid_o    = '0;
    command_ready_o = 1'b0;
    if (!reset) begin
      case (ds_q)
        DS_IDLE: command_ready_o = command_valid_i;
        DS_FWD: if (fwd_ok) begin
          port_valid_o[out_idx] = command_valid_i;
          command_ready_o       = port_ready_i[out_idx];
        end
        DS_DISC: command_ready_o = 1'b1;
        default: command_ready_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_q       <= DS_IDLE;
      word_cnt_q <= '0;
      out_port_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      case (ds_q)
        DS_IDLE: if (command_valid_i) begin
          word_cnt_q <= command_word_i[31:16];
          out_port_q <= command_word_i[15:0];
          if (command_word_i[31:16] == 16'd0)              ds_q <= DS_IDLE;
          else if (32'(command_word_i[15:0]) >= NUM_PORTS) ds_q <= DS_DISC;
          else                                             ds_q <= DS_FWD;
        end
        DS_FWD: if (ds_hs) begin
          word_cnt_q <= word_cnt_q - 16'd1;
          if (word_cnt_q == 16'd1) ds_q <= DS_IDLE;
        end
        DS_DISC: if (command_valid_i) begin
          word_cnt_q <= word_cnt_q - 16'd1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
          if (word_cnt_q == 16'd1) ds_q <= DS_IDLE;
        end
        default: ds_q <= DS_IDLE;
      endcase
    end
  end

  // Round-robin pick: walk offsets high to low so the lowest offset from rr_ptr wins
  always_comb begin
    sel     = '0;
    idx     = '0;
    any_vld = 1'b0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      idx = (int'(rr_ptr_q) + i >= NUM_PORTS) ? PORT_W'(int'(rr_ptr_q) + i - NUM_PORTS)
                                              : PORT_W'(int'(rr_ptr_q) + i);
      if (port_valid_i[idx]) begin
        sel     = idx;
        any_vld = 1'b1;
      end
    end
  end

  always_comb begin
    gword = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (grant_q == PORT_W'(p)) gword = port_word_i[32*p +: 32];
  end

  always_comb begin
    command_valid_o = 1'b0;
    command_word_o  = '0;
    port_ready_o    = '0;
    if (!reset) begin
      case (us_q)
        US_IDLE: if (any_vld) begin
          command_valid_o = 1'b1;
          command_word_o  = {16'd1, 16'(sel)};
        end
        US_PAYLOAD: begin
          command_valid_o       = port_valid_i[grant_q];
          command_word_o        = port_valid_i[grant_q] ? gword : 32'h0;
          port_ready_o[grant_q] = command_ready_i;
        end
        default: command_valid_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      us_q     <= US_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (us_q)
        US_IDLE: if (us_hs) begin
          grant_q <= sel;
          us_q    <= US_PAYLOAD;
        end
        US_PAYLOAD: if (us_hs) begin
          rr_ptr_q <= (grant_q == PORT_W'(NUM_PORTS-1)) ? '0 : grant_q + PORT_W'(1);
          us_q     <= US_IDLE;
        end
        default: us_q <= US_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_multi_router.sv
// Bench for uart_multi_router: per-cycle downstream vector table plus scoreboarded
// sequences for round-robin, grant lock, header backpressure and reset mid-packet.
module tb_uart_multi_router;
  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  cmd_w;
  logic         cmd_v;
  logic         cmd_rdy_o;
  logic [31:0]  up_w;
  logic         up_v;
  logic         up_rdy;
  logic [127:0] pw_o;
  logic [3:0]   pv_o;
  logic [3:0]   pr_i;
  logic [127:0] pw_i;
  logic [3:0]   pv_i;
  logic [3:0]   pr_o;
  logic [15:0]  drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_multi_router #(.NUM_PORTS(4)) dut (
    .clk(clk), .reset(reset),
    .command_word_i(cmd_w), .command_valid_i(cmd_v), .command_ready_o(cmd_rdy_o),
    .command_word_o(up_w), .command_valid_o(up_v), .command_ready_i(up_rdy),
    .port_word_o(pw_o), .port_valid_o(pv_o), .port_ready_i(pr_i),
    .port_word_i(pw_i), .port_valid_i(pv_i), .port_ready_o(pr_o),
    .drop_cnt_o(drop)
  );

  typedef struct packed { logic [1:0] port; logic [31:0] word; } dn_t;
  dn_t         dn_q[$];
  logic [31:0] up_q[$];

  typedef struct {
    logic [31:0] w;
    logic        v;
    logic [3:0]  pr;
    logic        exp_rdy;
    logic [3:0]  exp_pv;
    logic [15:0] exp_drop;
  } vec_t;
  vec_t vt[17];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [1:0] oh2i(input logic [3:0] v);
    oh2i = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) oh2i = 2'(i);
  endfunction

  // Scoreboard monitors sample mid-cycle; inputs only move just after the rising edge
  always @(negedge clk) begin : mon
    dn_t         e;
    logic [31:0] u;
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        if (pv_o[p] && pr_i[p]) begin
          checks++;
          if (dn_q.size() == 0) begin
            errors++;
            $display("FAIL dn_xfer port %0d got %h expected no transfer", p, pw_o[32*p +: 32]);
          end else begin
            e = dn_q.pop_front();
            if (e.port != 2'(p) || pw_o[32*p +: 32] !== e.word) begin
              errors++;
              $display("FAIL dn_xfer got port %0d word %h expected port %0d word %h",
                       p, pw_o[32*p +: 32], e.port, e.word);
            end
          end
        end
      end
      if (up_v && up_rdy) begin
        checks++;
        if (up_q.size() == 0) begin
          errors++;
          $display("FAIL up_xfer got %h expected no transfer", up_w);
        end else begin
          u = up_q.pop_front();
          if (up_w !== u) begin
            errors++;
            $display("FAIL up_xfer got %h expected %h", up_w, u);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Forward
    vt[0]  = '{32'h0003_0002, 1'b1, 4'b0100, 1'b1, 4'b0000, 16'd0};
    vt[1]  = '{32'h1111_AAAA, 1'b1, 4'b0100, 1'b1, 4'b0100, 16'd0};
    vt[2]  = '{32'h2222_BBBB, 1'b1, 4'b0100, 1'b1, 4'b0100, 16'd0};
    vt[3]  = '{32'h3333_CCCC, 1'b1, 4'b0100, 1'b1, 4'b0100, 16'd0};
    // Backpressure on the 2nd payload word
    vt[4]  = '{32'h0003_0002, 1'b1, 4'b0100, 1'b1, 4'b0000, 16'd0};
    vt[5]  = '{32'h4444_AAAA, 1'b1, 4'b0100, 1'b1, 4'b0100, 16'd0};
    vt[6]  = '{32'h5555_BBBB, 1'b1, 4'b0000, 1'b0, 4'b0100, 16'd0};
    vt[7]  = '{32'h5555_BBBB, 1'b1, 4'b0100, 1'b1, 4'b0100, 16'd0};
    vt[8]  = '{32'h6666_CCCC, 1'b1, 4'b0100, 1'b1, 4'b0100, 16'd0};
    vt[9]  = '{32'h0000_0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 16'd0};
    // Discard, then zero length
    vt[10] = '{32'h0002_0009, 1'b1, 4'b1111, 1'b1, 4'b0000, 16'd0};
    vt[11] = '{32'h7777_0001, 1'b1, 4'b1111, 1'b1, 4'b0000, 16'd0};
    vt[12] = '{32'h8888_0002, 1'b1, 4'b1111, 1'b1, 4'b0000, 16'd1};
    vt[13] = '{32'h0000_0001, 1'b1, 4'b0010, 1'b1, 4'b0000, 16'd2};
    vt[14] = '{32'h0001_0001, 1'b1, 4'b0010, 1'b1, 4'b0000, 16'd2};
    vt[15] = '{32'h9999_EEEE, 1'b1, 4'b0010, 1'b1, 4'b0010, 16'd2};
    vt[16] = '{32'h0000_0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 16'd2};

    pw_i = {32'hF333_3333, 32'hF222_2222, 32'hF111_1111, 32'hF000_0000};

    // Reset with every input asserted
    reset = 1'b1; cmd_w = 32'h0003_0002; cmd_v = 1'b1; pr_i = 4'hF; pv_i = 4'hF; up_rdy = 1'b1;
    tick(); tick();
    chk("rst_cmd_rdy", 0, 32'(cmd_rdy_o), 32'd0);
    chk("rst_pv",      0, 32'(pv_o), 32'd0);
    chk("rst_up_v",    0, 32'(up_v), 32'd0);
    chk("rst_pr",      0, 32'(pr_o), 32'd0);
    chk("rst_up_w",    0, up_w, 32'd0);
    chk("rst_drop",    0, 32'(drop), 32'd0);
    cmd_v = 1'b0; cmd_w = '0; pr_i = '0; pv_i = '0; reset = 1'b0;
    #1;
    chk("idle_up_v", 0, 32'(up_v), 32'd0);
    chk("idle_up_w", 0, up_w, 32'd0);

    for (int i = 0; i < 17; i++) begin
      cmd_w = vt[i].w; cmd_v = vt[i].v; pr_i = vt[i].pr;
      if (vt[i].v && vt[i].exp_rdy && vt[i].exp_pv != 4'd0)
        dn_q.push_back({oh2i(vt[i].exp_pv), vt[i].w});
      #1;
      chk("ds_rdy",   i, 32'(cmd_rdy_o), 32'(vt[i].exp_rdy));
      chk("ds_pv",    i, 32'(pv_o), 32'(vt[i].exp_pv));
      chk("ds_drop",  i, 32'(drop), 32'(vt[i].exp_drop));
      chk("ds_slice", i, pw_o[95:64], vt[i].w);
      tick();
    end
    chk("drop_final", 0, 32'(drop), 32'd2);
    chk("dn_q_empty", 0, 32'(dn_q.size()), 32'd0);

    // Round-robin between ports 0 and 3
    up_rdy = 1'b1; pv_i = 4'b1001;
    up_q.push_back(32'h0001_0000); up_q.push_back(32'hF000_0000);
    up_q.push_back(32'h0001_0003); up_q.push_back(32'hF333_3333);
    up_q.push_back(32'h0001_0000); up_q.push_back(32'hF000_0000);
    repeat (6) tick();
    pv_i = 4'b0000;
    chk("rr_q_empty", 0, 32'(up_q.size()), 32'd0);

    // Grant lock: port 1 wins the header then stalls while port 2 waits
    up_q.push_back(32'h0001_0001); up_q.push_back(32'hF111_1111);
    up_q.push_back(32'h0001_0002); up_q.push_back(32'hF222_2222);
    pv_i = 4'b0110;
    tick();
    pv_i = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock_up_v", i, 32'(up_v), 32'd0);
      chk("lock_up_w", i, up_w, 32'd0);
      chk("lock_pr",   i, 32'(pr_o), 32'b0010);
      tick();
    end
    pv_i = 4'b0110;
    repeat (3) tick();
    pv_i = 4'b0000;
    chk("lock_q_empty", 0, 32'(up_q.size()), 32'd0);

    // Header backpressure: sel follows the requesters until accepted
    up_rdy = 1'b0; pv_i = 4'b1000;
    #1;
    chk("bp_up_v", 0, 32'(up_v), 32'd1);
    chk("bp_up_w", 0, up_w, 32'h0001_0003);
    chk("bp_pr",   0, 32'(pr_o), 32'd0);
    tick();
    pv_i = 4'b0001;
    #1;
    chk("bp_up_w", 1, up_w, 32'h0001_0000);
    tick();
    pv_i = 4'b0000; up_rdy = 1'b1;

    // Reset after 1 of 3 payload words
    cmd_w = 32'h0003_0001; cmd_v = 1'b1; pr_i = 4'b0010;
    tick();
    cmd_w = 32'hAAAA_0001;
    dn_q.push_back({2'd1, 32'hAAAA_0001});
    tick();
    cmd_w = 32'hBBBB_0002; reset = 1'b1; pv_i = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("mrst_cmd_rdy", i, 32'(cmd_rdy_o), 32'd0);
      chk("mrst_pv",      i, 32'(pv_o), 32'd0);
      chk("mrst_up_v",    i, 32'(up_v), 32'd0);
      chk("mrst_pr",      i, 32'(pr_o), 32'd0);
      tick();
    end
    chk("mrst_drop", 0, 32'(drop), 32'd0);
    pv_i = 4'b0000; reset = 1'b0; cmd_w = 32'h0001_0002; pr_i = 4'b0100;
    #1;
    chk("post_hdr_rdy", 0, 32'(cmd_rdy_o), 32'd1);
    chk("post_hdr_pv",  0, 32'(pv_o), 32'd0);
    tick();
    cmd_w = 32'hCCCC_0003;
    dn_q.push_back({2'd2, 32'hCCCC_0003});
    #1;
    chk("post_pay_pv", 0, 32'(pv_o), 32'b0100);
    tick();
    cmd_v = 1'b0;

    // rr_ptr back at 0 after reset: port 1 beats port 3
    up_q.push_back(32'h0001_0001); up_q.push_back(32'hF111_1111);
    pv_i = 4'b1010;
    repeat (2) tick();
    pv_i = 4'b0000;
    tick();

    chk("final_dn_q", 0, 32'(dn_q.size()), 32'd0);
    chk("final_up_q", 0, 32'(up_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
